// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
//   FWD_*    : encodings for the 3:1 operand forwarding mux selects
//   state_t  : load-use stall sequencer states
//   CNT_W    : width of the stall bubble counter (covers 1..7 bubbles)
package fwd_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  localparam int CNT_W = 3;

endpackage

// File: rtl/fwd_hazard_ctrl_tag.sv
// fwd_stage_tag: one slot of the shadow pipeline that follows an instruction's
// register tags through EX, MEM and WB.
// Ports:
//   Clk, Rst_n          clock, async active-low reset (slot cleared to a bubble)
//   bubble              load an empty slot instead of the d_* fields
//   d_valid .. d_mem_read  incoming instruction tags
//   q_valid .. q_mem_read  registered instruction tags
module fwd_stage_tag
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              bubble,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [REG_AW-1:0] d_dst,
  input  logic              d_reg_write,
  input  logic              d_mem_read,
  output logic              q_valid,
  output logic [REG_AW-1:0] q_rs,
  output logic [REG_AW-1:0] q_rt,
  output logic [REG_AW-1:0] q_dst,
  output logic              q_reg_write,
  output logic              q_mem_read
);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      q_valid     <= 1'b0;
      q_rs        <= '0;
      q_rt        <= '0;
      q_dst       <= '0;
      q_reg_write <= 1'b0;
      q_mem_read  <= 1'b0;
    end else if (bubble) begin
      q_valid     <= 1'b0;
      q_rs        <= '0;
      q_rt        <= '0;
      q_dst       <= '0;
      q_reg_write <= 1'b0;
      q_mem_read  <= 1'b0;
    end else begin
      q_valid     <= d_valid;
      q_rs        <= d_rs;
      q_rt        <= d_rt;
      q_dst       <= d_dst;
      q_reg_write <= d_reg_write;
      q_mem_read  <= d_mem_read;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: drives the EX-stage operand forwarding selects and the
// load-use pipeline stall from a shadow copy of the EX/MEM/WB register tags.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | normal flow; stall only while a load-use hazard is visible
//   ST_STALL | extra bubbles owed for a load-use hazard; cnt = bubbles left
//
// Ports:
//   Clk, Rst_n                 clock, async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt, id_dst       ID source / destination register tags
//   id_reg_write, id_mem_read  ID instruction writes regfile / is a load
//   flush                      kill the ID instruction (branch/jump taken)
//   stall                      hold PC and IF/ID, ID/EX takes a bubble
//   fwd_a_sel, fwd_b_sel       operand A / B forwarding mux selects
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALL_CYC - 1);

  logic              ex_valid,  mem_valid,  wb_valid;
  logic [REG_AW-1:0] ex_rs,     mem_rs,     wb_rs;
  logic [REG_AW-1:0] ex_rt,     mem_rt,     wb_rt;
  logic [REG_AW-1:0] ex_dst,    mem_dst,    wb_dst;
  logic              ex_rw,     mem_rw,     wb_rw;
  logic              ex_mr,     mem_mr,     wb_mr;

  logic   ex_bubble;
  logic   hazard;
  logic   mem_fwd_ok, wb_fwd_ok;
  logic   unused_wb;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A stalled or flushed ID instruction must not reach EX.
  assign ex_bubble = ~(id_valid & ~flush & ~stall);

  fwd_stage_tag #(.REG_AW(REG_AW)) u_ex (
    .Clk(Clk), .Rst_n(Rst_n), .bubble(ex_bubble),
    .d_valid(id_valid), .d_rs(id_rs), .d_rt(id_rt), .d_dst(id_dst),
    .d_reg_write(id_reg_write), .d_mem_read(id_mem_read),
    .q_valid(ex_valid), .q_rs(ex_rs), .q_rt(ex_rt), .q_dst(ex_dst),
    .q_reg_write(ex_rw), .q_mem_read(ex_mr)
  );

  fwd_stage_tag #(.REG_AW(REG_AW)) u_mem (
    .Clk(Clk), .Rst_n(Rst_n), .bubble(1'b0),
    .d_valid(ex_valid), .d_rs(ex_rs), .d_rt(ex_rt), .d_dst(ex_dst),
    .d_reg_write(ex_rw), .d_mem_read(ex_mr),
    .q_valid(mem_valid), .q_rs(mem_rs), .q_rt(mem_rt), .q_dst(mem_dst),
    .q_reg_write(mem_rw), .q_mem_read(mem_mr)
  );

  fwd_stage_tag #(.REG_AW(REG_AW)) u_wb (
    .Clk(Clk), .Rst_n(Rst_n), .bubble(1'b0),
    .d_valid(mem_valid), .d_rs(mem_rs), .d_rt(mem_rt), .d_dst(mem_dst),
    .d_reg_write(mem_rw), .d_mem_read(mem_mr),
    .q_valid(wb_valid), .q_rs(wb_rs), .q_rt(wb_rt), .q_dst(wb_dst),
    .q_reg_write(wb_rw), .q_mem_read(wb_mr)
  );

  // WB source tags and load flag are carried only to keep the slots identical.
  assign unused_wb = ^{wb_rs, wb_rt, wb_mr};

  // $0 is hard-wired zero, so a write to it is never a forwarding source.
  assign mem_fwd_ok = mem_valid & mem_rw & (mem_dst != '0);
  assign wb_fwd_ok  = wb_valid  & wb_rw  & (wb_dst  != '0);

  // MEM is checked first: it holds the newer value of the register.
  always_comb begin
    fwd_a_sel = FWD_REGFILE;
    fwd_b_sel = FWD_REGFILE;
    if (ex_valid) begin
      if (mem_fwd_ok && (mem_dst == ex_rs))     fwd_a_sel = FWD_EXMEM;
      else if (wb_fwd_ok && (wb_dst == ex_rs))  fwd_a_sel = FWD_MEMWB;
      if (mem_fwd_ok && (mem_dst == ex_rt))     fwd_b_sel = FWD_EXMEM;
      else if (wb_fwd_ok && (wb_dst == ex_rt))  fwd_b_sel = FWD_MEMWB;
    end
  end

  assign hazard = id_valid & ex_valid & ex_mr & (ex_dst != '0) &
                  ((ex_dst == id_rs) | (ex_dst == id_rt));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first bubble is issued from ST_RUN; ST_STALL supplies the remainder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          stall = hazard;
          if (hazard && (LOAD_STALL_CYC > 1)) begin
            state_d = ST_STALL;
            cnt_d   = CNT_LOAD;
          end
        end
        ST_STALL: begin
          stall = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule
